// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues load/store over a req/ack handshake, stalls upstream while waiting.
// Define MEM_BYTE_ACCESS_EN to add byte accesses (byte_ins_in input, mem_be lane-enable output).
module mem_access_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] store_data_in,
    input  logic        ld_ins_in,
    input  logic        st_ins_in,
    input  logic        write_reg_in,
    input  logic [4:0]  rgD_index_in,
`ifdef MEM_BYTE_ACCESS_EN
    input  logic        byte_ins_in,
    output logic [3:0]  mem_be,
`endif
    output logic        stall_out,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_write,
    output logic [31:0] mem_data_out,
    output logic [31:0] data_out,
    output logic        write_reg_out,
    output logic        ld_ins_out,
    output logic [4:0]  rgD_index_out,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rdata;
    logic             r_we;
    logic             r_ld;
    logic             r_write_reg;
    logic             r_abort;
    logic [4:0]       r_rgd;
    logic [CNT_W-1:0] r_cnt;

    logic             w_mem_op;
    logic             w_is_byte;
    logic             w_misaligned;
    logic             w_accept;
    logic             w_timeout;
    logic [31:0]      w_store_data;
    logic [31:0]      w_load_data;

    assign w_mem_op     = ld_ins_in | st_ins_in;
    assign w_misaligned = w_mem_op && (alu_result_in[1:0] != 2'b00) && !w_is_byte;
    assign w_accept     = (r_state == S_IDLE) && valid_in && w_mem_op && !w_misaligned;
    assign w_timeout    = (r_cnt == CNT_W'(TIMEOUT - 1));

`ifdef MEM_BYTE_ACCESS_EN
    logic       r_byte;
    logic [3:0] r_be;

    assign w_is_byte    = byte_ins_in;
    assign w_store_data = byte_ins_in ? {4{store_data_in[7:0]}} : store_data_in;
    assign mem_be       = (r_state == S_REQ) ? r_be : 4'b0000;

    // Byte loads return the addressed lane zero-extended.
    always_comb begin
        w_load_data = mem_rdata;
        if (r_byte) begin
            case (r_addr[1:0])
                2'd0:    w_load_data = {24'd0, mem_rdata[7:0]};
                2'd1:    w_load_data = {24'd0, mem_rdata[15:8]};
                2'd2:    w_load_data = {24'd0, mem_rdata[23:16]};
                default: w_load_data = {24'd0, mem_rdata[31:24]};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_byte <= 1'b0;
            r_be   <= 4'b0000;
        end else if (w_accept) begin
            r_byte <= byte_ins_in;
            r_be   <= byte_ins_in ? (4'b0001 << alu_result_in[1:0]) : 4'b1111;
        end
    end
`else
    assign w_is_byte    = 1'b0;
    assign w_store_data = store_data_in;
    assign w_load_data  = mem_rdata;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_REQ;
            S_REQ:   if (mem_ack || w_timeout) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_rdata     <= 32'd0;
            r_we        <= 1'b0;
            r_ld        <= 1'b0;
            r_write_reg <= 1'b0;
            r_abort     <= 1'b0;
            r_rgd       <= 5'd0;
            r_cnt       <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_addr      <= alu_result_in;
                r_wdata     <= (st_ins_in && !ld_ins_in) ? w_store_data : 32'd0;
                r_we        <= st_ins_in && !ld_ins_in;
                r_ld        <= ld_ins_in;
                r_write_reg <= write_reg_in;
                r_rgd       <= rgD_index_in;
                r_rdata     <= 32'd0;
                r_abort     <= 1'b0;
                r_cnt       <= '0;
            end
            if (r_state == S_REQ) begin
                if (mem_ack) begin
                    r_rdata <= r_ld ? w_load_data : 32'd0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_timeout) r_abort <= 1'b1;
                end
            end
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        stall_out     = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = 32'd0;
        mem_wdata     = 32'd0;
        wb_write      = 1'b0;
        mem_data_out  = 32'd0;
        data_out      = 32'd0;
        write_reg_out = 1'b0;
        ld_ins_out    = 1'b0;
        rgD_index_out = 5'd0;
        mem_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (valid_in) begin
                    if (!w_mem_op) begin
                        wb_write      = 1'b1;
                        data_out      = alu_result_in;
                        write_reg_out = write_reg_in;
                        ld_ins_out    = ld_ins_in;
                        rgD_index_out = rgD_index_in;
                    end else if (w_misaligned) begin
                        wb_write      = 1'b1;
                        data_out      = alu_result_in;
                        ld_ins_out    = ld_ins_in;
                        rgD_index_out = rgD_index_in;
                        mem_err       = 1'b1;
                    end else begin
                        stall_out = 1'b1;
                    end
                end
            end
            S_REQ: begin
                stall_out = 1'b1;
                mem_req   = 1'b1;
                mem_we    = r_we;
                mem_addr  = {r_addr[31:2], 2'b00};
                mem_wdata = r_wdata;
            end
            S_DONE: begin
                wb_write      = 1'b1;
                data_out      = r_addr;
                mem_data_out  = r_rdata;
                write_reg_out = r_write_reg && !r_abort;
                ld_ins_out    = r_ld;
                rgD_index_out = r_rgd;
                mem_err       = r_abort;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: driver pushes expected M/WB records, a monitor pops them on wb_write.
module tb_mem_access_stage;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 5;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic [31:0] alu_result_in;
    logic [31:0] store_data_in;
    logic        ld_ins_in;
    logic        st_ins_in;
    logic        write_reg_in;
    logic [4:0]  rgD_index_in;
    logic        stall_out;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_write;
    logic [31:0] mem_data_out;
    logic [31:0] data_out;
    logic        write_reg_out;
    logic        ld_ins_out;
    logic [4:0]  rgD_index_out;
    logic        mem_err;
`ifdef MEM_BYTE_ACCESS_EN
    logic        byte_ins_in = 1'b0;
    logic [3:0]  mem_be;
`endif

    mem_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .valid_in      (valid_in),
        .alu_result_in (alu_result_in),
        .store_data_in (store_data_in),
        .ld_ins_in     (ld_ins_in),
        .st_ins_in     (st_ins_in),
        .write_reg_in  (write_reg_in),
        .rgD_index_in  (rgD_index_in),
`ifdef MEM_BYTE_ACCESS_EN
        .byte_ins_in   (byte_ins_in),
        .mem_be        (mem_be),
`endif
        .stall_out     (stall_out),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .wb_write      (wb_write),
        .mem_data_out  (mem_data_out),
        .data_out      (data_out),
        .write_reg_out (write_reg_out),
        .ld_ins_out    (ld_ins_out),
        .rgD_index_out (rgD_index_out),
        .mem_err       (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data_out;
        logic [31:0] mem_data;
        logic        write_reg;
        logic        ld_ins;
        logic [4:0]  rgd;
        logic        err;
        bit          chk_data;
        bit          chk_mdata;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what M/WB must receive for one instruction, from the architectural rules.
    function automatic exp_t model(input logic [31:0] addr, input logic [31:0] rdata,
                                   input logic ld, input logic st, input logic wr,
                                   input logic [4:0] rgd, input bit timed_out);
        exp_t e;
        e.data_out  = addr;
        e.mem_data  = 32'd0;
        e.write_reg = wr;
        e.ld_ins    = ld;
        e.rgd       = rgd;
        e.err       = 1'b0;
        e.chk_data  = 1'b1;
        e.chk_mdata = 1'b1;
        if (ld || st) begin
            if (addr % 4 != 0) begin
                e.err       = 1'b1;
                e.write_reg = 1'b0;
                e.chk_data  = 1'b0;
                e.chk_mdata = 1'b0;
            end else if (timed_out) begin
                e.err       = 1'b1;
                e.write_reg = 1'b0;
                e.chk_mdata = 1'b0;
            end else if (ld) begin
                e.mem_data = rdata;
            end
        end
        return e;
    endfunction

    // Monitor: every wb_write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (wb_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wb_write", {31'd0, wb_write}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("write_reg_out", {31'd0, write_reg_out}, {31'd0, e.write_reg});
                check("mem_err", {31'd0, mem_err}, {31'd0, e.err});
                if (e.chk_data) begin
                    check("data_out", data_out, e.data_out);
                    check("ld_ins_out", {31'd0, ld_ins_out}, {31'd0, e.ld_ins});
                    check("rgD_index_out", {27'd0, rgD_index_out}, {27'd0, e.rgd});
                end
                if (e.chk_mdata) check("mem_data_out", mem_data_out, e.mem_data);
            end
        end else if (mem_err !== 1'b0) begin
            check("mem_err_without_wb", {31'd0, mem_err}, 32'd0);
        end
    end

    task automatic idle(input int n);
        valid_in  = 1'b0;
        ld_ins_in = 1'b0;
        st_ins_in = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one instruction and acts as the memory; called and returns at posedge+1.
    task automatic do_op(input logic [31:0] addr, input logic [31:0] sdata,
                         input logic ld, input logic st, input logic wr,
                         input logic [4:0] rgd, input int waits, input bit no_ack);
        logic [31:0] rdata;
        bit          aligned_mem;
        int          exp_req;
        int          req_cycles;
        int          stall_cycles;
        bit          done;
        logic        st_now;
        rdata        = $urandom();
        aligned_mem  = (ld || st) && (addr % 4 == 0);
        exp_req      = !aligned_mem ? 0 : (no_ack ? TIMEOUT : waits + 1);
        exp_q.push_back(model(addr, rdata, ld, st, wr, rgd, no_ack));
        valid_in      = 1'b1;
        alu_result_in = addr;
        store_data_in = sdata;
        ld_ins_in     = ld;
        st_ins_in     = st;
        write_reg_in  = wr;
        rgD_index_in  = rgd;
        req_cycles    = 0;
        stall_cycles  = 0;
        done          = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                check("mem_addr", mem_addr, addr);
                check("mem_we", {31'd0, mem_we}, {31'd0, st && !ld});
                if (st && !ld) check("mem_wdata", mem_wdata, sdata);
                if (!no_ack && req_cycles == waits) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end
                req_cycles++;
            end
            st_now = stall_out;
            if (st_now === 1'b1) begin
                stall_cycles++;
                if (wb_write !== 1'b0) check("wb_write_while_stalled", {31'd0, wb_write}, 32'd0);
            end
            @(posedge clk);
            #1;
            mem_ack   = 1'b0;
            mem_rdata = $urandom();
            if (st_now !== 1'b1) done = 1'b1;
        end
        check("op_completed", {31'd0, done}, 32'd1);
        check("req_cycles", 32'(req_cycles), 32'(exp_req));
        check("stall_cycles", 32'(stall_cycles), aligned_mem ? 32'(exp_req + 1) : 32'd0);
        valid_in = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b0;
        valid_in      = 1'b0;
        alu_result_in = 32'd0;
        store_data_in = 32'd0;
        ld_ins_in     = 1'b0;
        st_ins_in     = 1'b0;
        write_reg_in  = 1'b0;
        rgD_index_in  = 5'd0;
        mem_ack       = 1'b0;
        mem_rdata     = 32'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall_out", {31'd0, stall_out}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_wb_write", {31'd0, wb_write}, 32'd0);
        check("rst_mem_data_out", mem_data_out, 32'd0);
        check("rst_data_out", data_out, 32'd0);
        check("rst_write_reg_out", {31'd0, write_reg_out}, 32'd0);
        check("rst_ld_ins_out", {31'd0, ld_ins_out}, 32'd0);
        check("rst_rgD_index_out", {27'd0, rgD_index_out}, 32'd0);
        check("rst_mem_err", {31'd0, mem_err}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(1);

        do_op(32'h0000_0042, 32'd0, 1'b0, 1'b0, 1'b1, 5'd5, 0, 1'b0);
        idle(1);
        do_op(32'h0000_0100, 32'd0, 1'b1, 1'b0, 1'b1, 5'd7, 2, 1'b0);
        idle(1);
        do_op(32'h0000_0200, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 5'd3, 0, 1'b0);
        idle(1);
        do_op(32'h0000_0102, 32'd0, 1'b1, 1'b0, 1'b1, 5'd9, 0, 1'b0);
        idle(1);
        do_op(32'h0000_0300, 32'd0, 1'b1, 1'b0, 1'b1, 5'd4, 0, 1'b1);
        idle(1);
        do_op(32'h0000_0400, 32'hCAFE_F00D, 1'b1, 1'b1, 1'b1, 5'd12, 1, 1'b0);
        idle(1);

        // Reset asserted during the second REQ cycle, then a stray ack.
        valid_in      = 1'b1;
        alu_result_in = 32'h0000_0500;
        ld_ins_in     = 1'b1;
        st_ins_in     = 1'b0;
        write_reg_in  = 1'b1;
        rgD_index_in  = 5'd2;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset    = 1'b1;
        valid_in = 1'b0;
        @(negedge clk);
        check("rstmid_mem_req", {31'd0, mem_req}, 32'd0);
        check("rstmid_stall_out", {31'd0, stall_out}, 32'd0);
        @(posedge clk);
        #1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        check("late_ack_wb_write", {31'd0, wb_write}, 32'd0);
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        idle(2);

        for (int n = 0; n < 200; n++) begin
            int          kind;
            logic [31:0] addr;
            logic        ld;
            logic        st;
            logic        wr;
            kind = $urandom_range(0, 9);
            addr = $urandom() & 32'hFFFF_FFFC;
            wr   = 1'($urandom_range(0, 1));
            ld   = 1'b0;
            st   = 1'b0;
            case (kind)
                0, 1:    ;
                2, 3, 4: ld = 1'b1;
                5, 6:    begin st = 1'b1; wr = 1'b0; end
                7:       begin ld = 1'b1; st = 1'b1; end
                default: begin
                    ld   = 1'($urandom_range(0, 1));
                    st   = !ld;
                    addr = addr | 32'($urandom_range(1, 3));
                end
            endcase
            do_op(addr, $urandom(), ld, st, wr, 5'($urandom_range(0, 31)),
                  $urandom_range(0, 4), ($urandom_range(0, 19) == 0));
            idle($urandom_range(0, 2));
        end

        idle(4);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
